// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one valid/ready pipeline input between NUM_REQ masters.
// A grant lasts at most MAX_BURST accepted beats and is never revoked while a beat is pending.
module rr_handshake_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 3,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      valid_up,
    output logic [DATA_W-1:0]         data_up,
    input  logic                      ready_up,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [ID_W-1:0]  gnt, gnt_n;
    logic [ID_W-1:0]  last_gnt, last_gnt_n;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;

    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  cand;
    logic             gnt_valid;
    logic [DATA_W-1:0] gnt_data;
    logic             handshake;

    // First requester strictly after last_gnt, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == ID_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake semantics: a beat transfers on a cycle where valid_up and ready_up are
    // both high; masters hold valid and data stable until that happens.
    always_comb begin
        req_ready = '0;
        valid_up  = 1'b0;
        data_up   = '0;
        if (state == GRANT) begin
            valid_up = gnt_valid;
            data_up  = gnt_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt == ID_W'(i)) begin
                    req_ready[i] = ready_up;
                end
            end
        end
    end

    assign handshake    = valid_up & ready_up;
    assign grant_active = (state == GRANT);
    assign grant_id     = gnt;

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        last_gnt_n = last_gnt;
        beat_cnt_n = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_n      = pick_id;
                    beat_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                // An idle owner has no pending beat, so the grant can go immediately.
                if (!gnt_valid ||
                    (handshake && beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                    last_gnt_n = gnt;
                    beat_cnt_n = '0;
                    state_n    = IDLE;
                end else if (handshake) begin
                    beat_cnt_n = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            last_gnt <= last_gnt_n;
            beat_cnt <= beat_cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter: per-cycle expected tables, a beat scoreboard
// on the upstream port, and bench-driven masters that only advance after a handshake.
module tb_rr_handshake_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 3;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;

    logic                      sys_clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      valid_up;
    logic [DATA_W-1:0]         data_up;
    logic                      ready_up;
    logic                      grant_active;
    logic [ID_W-1:0]           grant_id;

    int total = 0;
    int bad   = 0;
    int left[NUM_REQ];
    logic sb_en = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    rr_handshake_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .ID_W     (ID_W)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .valid_up    (valid_up),
        .data_up     (data_up),
        .ready_up    (ready_up),
        .grant_active(grant_active),
        .grant_id    (grant_id)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard on accepted upstream beats
    always @(negedge sys_clk) begin
        if (sb_en && !rst && valid_up && ready_up) begin
            if (exp_q.size() == 0) chk("sb_extra_beat", 32'(data_up), 32'hffff_ffff);
            else chk("sb_beat", 32'(data_up), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        ready_up  = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input int i, input int n, input logic [DATA_W-1:0] d);
        left[i] = n;
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Called at the negedge: records handshakes, moves to the next cycle, advances masters.
    task automatic adv();
        logic [NUM_REQ-1:0] hs;
        hs = req_valid & req_ready;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                left[i] = left[i] - 1;
                if (left[i] == 0) begin
                    req_valid[i] = 1'b0;
                    req_data[i*DATA_W +: DATA_W] = '0;
                end else begin
                    req_data[i*DATA_W +: DATA_W] = DATA_W'(req_data[i*DATA_W +: DATA_W] + 1);
                end
            end
        end
    endtask

    task automatic check_cycle(input string tag, input int c, input int ga, input int vu,
                               input int du, input int rr, input int id);
        chk($sformatf("%s c%0d grant_active", tag, c), 32'(grant_active), 32'(ga));
        chk($sformatf("%s c%0d valid_up", tag, c), 32'(valid_up), 32'(vu));
        chk($sformatf("%s c%0d data_up", tag, c), 32'(data_up), 32'(du));
        chk($sformatf("%s c%0d req_ready", tag, c), 32'(req_ready), 32'(rr));
        chk($sformatf("%s c%0d grant_id", tag, c), 32'(grant_id), 32'(id));
    endtask

    task automatic sc_single();
        int ga_t[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        int vu_t[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        int du_t[10] = '{0, 1, 2, 3, 4, 0, 5, 6, 0, 0};
        do_reset();
        for (int b = 1; b <= 6; b++) exp_q.push_back(DATA_W'(b));
        sb_en = 1'b1;
        load(0, 6, 3'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            check_cycle("single", c, ga_t[c], vu_t[c], du_t[c], ga_t[c] ? 1 : 0, 0);
            adv();
        end
        sb_en = 1'b0;
        chk("single sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sc_all();
        int p, r, ga, id;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) load(i, 1000, DATA_W'(i));
        for (int c = 0; c < 26; c++) begin
            @(negedge sys_clk);
            if (c == 0) begin
                ga = 0;
                id = 0;
            end else begin
                p  = (c - 1) % 5;
                r  = (c - 1) / 5;
                ga = (p != 4) ? 1 : 0;
                id = r % 4;
            end
            chk($sformatf("all c%0d grant_active", c), 32'(grant_active), 32'(ga));
            chk($sformatf("all c%0d grant_id", c), 32'(grant_id), 32'(id));
            chk($sformatf("all c%0d valid_up", c), 32'(valid_up), 32'(ga));
            chk($sformatf("all c%0d req_ready", c), 32'(req_ready), ga ? (32'd1 << id) : 32'd0);
            chk($sformatf("all c%0d onehot", c), 32'($countones(req_ready) <= 1), 32'd1);
            adv();
        end
    endtask

    task automatic sc_stall();
        int rdy_t[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int ga_t[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int vu_t[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int du_t[9]  = '{0, 3, 4, 5, 5, 5, 5, 6, 0};
        int rr_t[9]  = '{0, 4, 4, 0, 0, 0, 4, 4, 0};
        int id_t[9]  = '{0, 2, 2, 2, 2, 2, 2, 2, 2};
        do_reset();
        for (int b = 3; b <= 6; b++) exp_q.push_back(DATA_W'(b));
        sb_en = 1'b1;
        load(2, 4, 3'd3);
        for (int c = 0; c < 9; c++) begin
            ready_up = rdy_t[c][0];
            @(negedge sys_clk);
            check_cycle("stall", c, ga_t[c], vu_t[c], du_t[c], rr_t[c], id_t[c]);
            adv();
        end
        sb_en    = 1'b0;
        ready_up = 1'b1;
        chk("stall sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sc_early();
        int ga_t[6] = '{0, 1, 1, 1, 0, 1};
        int vu_t[6] = '{0, 1, 1, 0, 0, 1};
        int du_t[6] = '{0, 1, 2, 0, 0, 7};
        int rr_t[6] = '{0, 2, 2, 2, 0, 8};
        int id_t[6] = '{0, 1, 1, 1, 1, 3};
        do_reset();
        load(1, 2, 3'd1);
        load(3, 100, 3'd7);
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            check_cycle("early", c, ga_t[c], vu_t[c], du_t[c], rr_t[c], id_t[c]);
            adv();
        end
    endtask

    task automatic sc_reset_mid();
        do_reset();
        load(1, 4, 3'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            adv();
        end
        // cycle 3: master 1 still presenting beat 3 when reset is applied
        rst = 1'b1;
        load(0, 2, 3'd5);
        @(negedge sys_clk);
        chk("rstmid c3 grant_active", 32'(grant_active), 32'd1);
        chk("rstmid c3 data_up", 32'(data_up), 32'd3);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        @(negedge sys_clk);
        check_cycle("rstmid", 4, 0, 0, 0, 0, 0);
        adv();
        @(negedge sys_clk);
        check_cycle("rstmid", 5, 1, 1, 5, 1, 0);
        adv();
    endtask

    task automatic sc_wrap();
        do_reset();
        load(3, 2, 3'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            adv();
        end
        // cycle 3: master 3 has dropped valid (release cycle) and master 0 rises now
        load(0, 2, 3'd4);
        @(negedge sys_clk);
        check_cycle("wrap", 3, 1, 0, 0, 8, 3);
        adv();
        @(negedge sys_clk);
        check_cycle("wrap", 4, 0, 0, 0, 0, 3);
        adv();
        @(negedge sys_clk);
        check_cycle("wrap", 5, 1, 1, 4, 1, 0);
        adv();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        ready_up  = 1'b0;
        do_reset();
        @(negedge sys_clk);
        check_cycle("reset", 0, 0, 0, 0, 0, 0);
        @(posedge sys_clk);
        #1;

        sc_single();
        sc_all();
        sc_stall();
        sc_early();
        sc_reset_mid();
        sc_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
